// File: rtl/fsm_seq_decoder_pkg.sv
// Shared definitions for the 4-state Mealy sequence code.
// Holds the state encoding, byte width and the recovery / next-state
// tables as functions so the encoder, decoder and benches all agree.
package fsm_seq_decoder_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = $clog2(BYTE_W);
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_e;

    // Recover data bit x from the current state and channel symbol y.
    function automatic logic recover_bit(input state_e s, input logic y);
        logic x;
        case (s)
            S0, S3:  x = ~y;
            default: x = y;
        endcase
        return x;
    endfunction

    // Encoder-side mapping of data bit x to channel symbol y.
    // The inversion is symmetric, so it matches recover_bit.
    function automatic logic encode_bit(input state_e s, input logic x);
        logic y;
        case (s)
            S0, S3:  y = ~x;
            default: y = x;
        endcase
        return y;
    endfunction

    // State transition driven by the data bit, shared by encoder and decoder.
    function automatic state_e next_state(input state_e s, input logic x);
        state_e n;
        case (s)
            S0:      n = x ? S2 : S1;
            S1:      n = x ? S3 : S2;
            S2:      n = x ? S3 : S1;
            default: n = x ? S0 : S2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fsm_seq_inverse_core.sv
// Per-bit inverse of the 4-state Mealy sequence encoder.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   sync_i             force state to S0 next edge, suppresses decode
//   in_valid_i, y_i    channel symbol and its qualifier
//   bit_c_o            combinational recovered bit for the current symbol
//   bit_valid_c_o      combinational: bit_c_o is decoded on this edge
//   x_o, x_valid_o     registered recovered bit and one-cycle strobe
//   state_o            current decoder state register
module fsm_seq_inverse_core
    import fsm_seq_decoder_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sync_i,
    input  logic   in_valid_i,
    input  logic   y_i,
    output logic   bit_c_o,
    output logic   bit_valid_c_o,
    output logic   x_o,
    output logic   x_valid_o,
    output state_e state_o
);

    state_e state_q, state_d;
    logic   x_q, x_d;
    logic   x_valid_q, x_valid_d;
    logic   bit_c;
    logic   bit_valid_c;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
        end
    end

    // Next-state and decode; sync wins over in_valid.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        x_valid_d   = 1'b0;
        bit_c       = recover_bit(state_q, y_i);
        bit_valid_c = in_valid_i & ~sync_i;

        if (sync_i) begin
            state_d = S0;
        end else if (in_valid_i) begin
            state_d   = next_state(state_q, bit_c);
            x_d       = bit_c;
            x_valid_d = 1'b1;
        end
    end

    assign bit_c_o       = bit_c;
    assign bit_valid_c_o = bit_valid_c;
    assign x_o           = x_q;
    assign x_valid_o     = x_valid_q;
    assign state_o       = state_q;

endmodule

// File: rtl/fsm_seq_decoder.sv
// Sequence decoder: recovers data bits from the 4-state Mealy code and
// assembles them LSB-first into bytes with a valid/ready style handoff.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   sync                 resynchronise decoder to S0, clear partial byte and overflow
//   in_valid, y_in       channel symbol and its qualifier
//   x_out, x_valid       recovered bit and one-cycle strobe (latency 1)
//   byte_data            assembled byte, bit 0 = first received bit
//   byte_valid           byte_data holds an unconsumed byte
//   out_ready            consumer takes byte_data on this edge
//   overflow             sticky: a completed byte was dropped
//   state                current decoder state (debug)
module fsm_seq_decoder
    import fsm_seq_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              in_valid,
    input  logic              y_in,
    output logic              x_out,
    output logic              x_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [STATE_W-1:0] state
);

    logic   bit_c;
    logic   bit_valid_c;
    state_e core_state;

    fsm_seq_inverse_core u_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .sync_i        (sync),
        .in_valid_i    (in_valid),
        .y_i           (y_in),
        .bit_c_o       (bit_c),
        .bit_valid_c_o (bit_valid_c),
        .x_o           (x_out),
        .x_valid_o     (x_valid),
        .state_o       (core_state)
    );

    // Only the first seven bits need storing; the eighth arrives with
    // the completing symbol and goes straight into byte_data.
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-2:0] partial_q, partial_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              overflow_q, overflow_d;
    logic              byte_done_c;
    logic [BYTE_W-1:0] new_byte_c;

    // Byte assembly and handoff registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            partial_q    <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            partial_q    <= partial_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // Shift in recovered bits, complete bytes and arbitrate the handoff.
    always_comb begin
        cnt_d        = cnt_q;
        partial_d    = partial_q;
        byte_d       = byte_q;
        byte_valid_d = byte_valid_q;
        overflow_d   = overflow_q;
        byte_done_c  = 1'b0;
        new_byte_c   = {bit_c, partial_q};

        if (sync) begin
            cnt_d      = '0;
            partial_d  = '0;
            overflow_d = 1'b0;
        end else if (bit_valid_c) begin
            if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                cnt_d       = '0;
                partial_d   = '0;
                byte_done_c = 1'b1;
            end else begin
                cnt_d     = cnt_q + CNT_W'(1);
                partial_d = {bit_c, partial_q[BYTE_W-2:1]};
            end
        end

        // Consumer takes the pending byte.
        if (out_ready && byte_valid_q) begin
            byte_valid_d = 1'b0;
        end

        // A new byte lands if the slot is free or being freed this edge.
        if (byte_done_c) begin
            if (!byte_valid_q || out_ready) begin
                byte_d       = new_byte_c;
                byte_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    assign byte_data  = byte_q;
    assign byte_valid = byte_valid_q;
    assign overflow   = overflow_q;
    assign state      = STATE_W'(core_state);

endmodule

// File: tb/tb_fsm_seq_decoder.sv
module tb_fsm_seq_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       in_valid;
    logic       y_in;
    logic       x_out;
    logic       x_valid;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       out_ready;
    logic       overflow;
    logic [1:0] state;

    fsm_seq_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .in_valid   (in_valid),
        .y_in       (y_in),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .state      (state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Code tables: x = y ^ INV[s]; next state from N0 (x=0) / N1 (x=1).
    int INV[4] = '{1, 0, 0, 1};
    int N0[4]  = '{1, 2, 1, 2};
    int N1[4]  = '{2, 3, 3, 0};

    // Reference stream: y symbols from S0 and the bits they carry (byte 8'h5C).
    int ys[8] = '{1, 0, 1, 0, 0, 0, 1, 1};
    int xs[8] = '{0, 0, 1, 1, 1, 0, 1, 0};

    // Behavioural model of the visible outputs.
    int m_state, m_x, m_xv, m_cnt, m_part, m_byte, m_bv, m_ovf;
    int enc_state;
    bit sent[$];

    task automatic model_reset();
        m_state = 0; m_x = 0; m_xv = 0; m_cnt = 0;
        m_part = 0; m_byte = 0; m_bv = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        int x;
        int done;
        int nb;
        int old_bv;
        done   = 0;
        nb     = 0;
        old_bv = m_bv;
        m_xv   = 0;
        if (sync) begin
            m_state = 0; m_cnt = 0; m_part = 0; m_ovf = 0;
        end else if (in_valid) begin
            x       = int'(y_in) ^ INV[m_state];
            m_x     = x;
            m_xv    = 1;
            m_state = x ? N1[m_state] : N0[m_state];
            m_part  = m_part + (x << m_cnt);
            if (m_cnt == 7) begin
                done = 1; nb = m_part; m_part = 0; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (out_ready && old_bv != 0) m_bv = 0;
        if (done != 0) begin
            if (old_bv == 0 || out_ready) begin
                m_byte = nb; m_bv = 1;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("x_valid", x_valid, m_xv);
        check("x_out", x_out, m_x);
        check("state", state, m_state);
        check("byte_data", byte_data, m_byte);
        check("byte_valid", byte_valid, m_bv);
        check("overflow", overflow, m_ovf);
    endtask

    // One clock edge: update model, wait, then compare away from the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_sync();
        sync = 1'b1; in_valid = 1'b0;
        tick();
        sync = 1'b0;
        enc_state = 0;
    endtask

    task automatic consume();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Drive symbols ys[first..last] with in_valid; optionally check x_out.
    task automatic send_ys(input int first, input int last, input bit chk_x, input bit rdy_last);
        for (int i = first; i <= last; i++) begin
            in_valid  = 1'b1;
            y_in      = 1'(ys[i]);
            out_ready = (rdy_last && i == last) ? 1'b1 : 1'b0;
            tick();
            if (chk_x) check("stream_x", x_out, xs[i]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int xb;
        rst_n = 1'b0; sync = 1'b0; in_valid = 1'b0; y_in = 1'b0; out_ready = 1'b0;
        enc_state = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_byte", byte_data, 8'h00);
        rst_n = 1'b1;

        // Basic stream from reset.
        send_ys(0, 7, 1'b1, 1'b0);
        check("s1_byte", byte_data, 8'h5C);
        check("s1_bv", byte_valid, 1);
        check("s1_state", state, 2);
        consume();
        check("s1_consumed", byte_valid, 0);

        // Same stream with a 3-cycle gap after the 4th symbol.
        do_sync();
        send_ys(0, 3, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick();
            check("gap_state", state, 0);
            check("gap_xv", x_valid, 0);
        end
        send_ys(4, 7, 1'b1, 1'b0);
        check("s2_byte", byte_data, 8'h5C);
        consume();

        // Two bytes back to back with no consumer: second is dropped.
        do_sync();
        send_ys(0, 7, 1'b0, 1'b0);
        send_ys(0, 7, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_kept", byte_data, 8'h5C);
        do_sync();
        check("ovf_cleared", overflow, 0);
        check("ovf_bv_kept", byte_valid, 1);
        check("ovf_sync_state", state, 0);
        consume();

        // Consumer ready on the very edge the second byte completes.
        do_sync();
        send_ys(0, 7, 1'b0, 1'b0);
        send_ys(0, 7, 1'b0, 1'b1);
        check("same_edge_bv", byte_valid, 1);
        check("same_edge_byte", byte_data, 8'h43);
        check("same_edge_ovf", overflow, 0);
        consume();

        // sync mid-byte discards partial bits.
        do_sync();
        send_ys(0, 4, 1'b0, 1'b0);
        do_sync();
        check("midsync_state", state, 0);
        send_ys(0, 7, 1'b1, 1'b0);
        check("midsync_byte", byte_data, 8'h5C);

        // Reset asserted mid-byte while in S3, with a byte still pending.
        do_sync();
        send_ys(0, 2, 1'b0, 1'b0);
        check("pre_rst_state", state, 3);
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        check("rst_bv", byte_valid, 0);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        send_ys(0, 7, 1'b1, 1'b0);
        check("post_rst_byte", byte_data, 8'h5C);
        consume();

        // Random bit stream through the reference encoder.
        do_sync();
        n = 0;
        while (n < 1000) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                tick();
            end else begin
                xb        = int'($urandom_range(0, 1));
                y_in      = 1'(xb ^ INV[enc_state]);
                enc_state = (xb != 0) ? N1[enc_state] : N0[enc_state];
                sent.push_back(xb[0]);
                in_valid  = 1'b1;
                tick();
                n++;
            end
            if (x_valid) begin
                if (sent.size() == 0) check("rand_extra", 1, 0);
                else check("rand_bit", x_out, sent.pop_front());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check("rand_left", sent.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
